// File: rtl/cog_pkg.sv
// Shared definitions for the cog counter capture stage: cfg field layout,
// edge-mode encoding and the decoded configuration record.
package cog_pkg;

   localparam int unsigned PIN_LSB   = 0;
   localparam int unsigned MODE_LSB  = 5;
   localparam int unsigned DELTA_BIT = 7;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   typedef struct packed {
      logic       delta;
      mode_e      mode;
      logic [4:0] pin;
   } cfg_t;

   function automatic cfg_t decode_cfg(input logic [7:0] d);
      cfg_t c;
      c.pin   = d[PIN_LSB +: 5];
      c.mode  = mode_e'(d[MODE_LSB +: 2]);
      c.delta = d[DELTA_BIT];
      return c;
   endfunction

endpackage

// File: rtl/cog_fifo.sv
// First-word-fall-through FIFO with explicit occupancy count and a flush input.
// Reading while empty is ignored; reading while full lets a write in the same cycle.
module cog_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          wr,
   input  logic [31:0]   wdata,
   input  logic          rd,
   output logic [31:0]   rdata,
   output logic          valid,
   output logic          full,
   output logic [AW:0]   count
);

   logic [31:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign valid  = (r_count != '0);
   assign full   = (r_count == (AW+1)'(DEPTH));
   assign w_pop  = rd & valid;
   assign w_push = wr & (~full | w_pop);
   assign count  = r_count;
   assign rdata  = valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: valid gates rdata and the pointers restart on reset.
   always_ff @(posedge clk) begin
      if (w_push && !rst && !flush) r_mem[r_wr_ptr] <= wdata;
   end

endmodule

// File: rtl/cog_ctr_capture.sv
// Edge-timestamp capture: snapshots phs[31:0] (raw or as a delta from the
// previous edge) on a qualifying edge of one selected pin into a small FIFO.
module cog_ctr_capture
   import cog_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk_cog,
   input  logic          res,
   input  logic          ena,
   input  logic          cfg_set,
   input  logic [31:0]   cfg_data,
   input  logic [32:0]   phs,
   input  logic [31:0]   pin_in,
   input  logic          rd,
   output logic [31:0]   dout,
   output logic          valid,
   output logic [AW:0]   count,
   output logic          ovf
);

   cfg_t        r_cfg;
   logic [1:0]  r_dly;
   logic [1:0]  r_nsamp;
   logic [31:0] r_last;
   logic        r_primed;
   logic        r_ovf;

   logic        w_rst;
   logic        w_event;
   logic        w_produce;
   logic [31:0] w_wdata;
   logic        w_wr;
   logic        w_rd;
   logic        w_full;
   logic        w_drop;
   logic        w_unused;

   assign w_unused = ^{phs[32], cfg_data[31:8]};
   assign w_rst    = res | ~ena;

   // An edge is only trusted once dly holds two samples taken since the last clear.
   always_comb begin
      w_event = 1'b0;
      if (r_nsamp == 2'd2) begin
         case (r_cfg.mode)
            MODE_RISE: w_event = (r_dly == 2'b01);
            MODE_FALL: w_event = (r_dly == 2'b10);
            MODE_BOTH: w_event = r_dly[1] ^ r_dly[0];
            default:   w_event = 1'b0;
         endcase
      end
   end

   assign w_produce = w_event & (~r_cfg.delta | r_primed);
   assign w_wdata   = r_cfg.delta ? (phs[31:0] - r_last) : phs[31:0];
   assign w_wr      = w_produce & ~cfg_set;
   assign w_rd      = rd & ~cfg_set;
   assign w_drop    = w_produce & w_full & ~(rd & valid) & ~cfg_set;

   always_ff @(posedge clk_cog) begin
      if (w_rst) begin
         r_cfg    <= '0;
         r_dly    <= '0;
         r_nsamp  <= '0;
         r_last   <= '0;
         r_primed <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (cfg_set) begin
         r_cfg    <= decode_cfg(cfg_data[7:0]);
         r_dly    <= '0;
         r_nsamp  <= '0;
         r_primed <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (r_cfg.mode != MODE_OFF) begin
            r_dly   <= {r_dly[0], pin_in[r_cfg.pin]};
            r_nsamp <= (r_nsamp == 2'd2) ? 2'd2 : r_nsamp + 2'd1;
         end
         // last follows every event, including dropped ones and the priming one.
         if (w_event) begin
            r_last   <= phs[31:0];
            r_primed <= 1'b1;
         end
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   cog_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk_cog),
      .rst   (w_rst),
      .flush (cfg_set),
      .wr    (w_wr),
      .wdata (w_wdata),
      .rd    (w_rd),
      .rdata (dout),
      .valid (valid),
      .full  (w_full),
      .count (count)
   );

   assign ovf = r_ovf;

endmodule

// File: tb/tb_cog_ctr_capture.sv
// Self-checking bench for cog_ctr_capture: directed scenarios plus a randomized
// run compared every cycle against a queue-based behavioural model.
module tb_cog_ctr_capture;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   logic          clk_cog = 1'b0;
   logic          res = 1'b1;
   logic          ena = 1'b1;
   logic          cfg_set = 1'b0;
   logic [31:0]   cfg_data = '0;
   logic [32:0]   phs = '0;
   logic [31:0]   pin_in = '0;
   logic          rd = 1'b0;
   logic [31:0]   dout;
   logic          valid;
   logic [AW:0]   count;
   logic          ovf;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   int          m_pin = 0;
   int          m_mode = 0;
   bit          m_delta = 0;
   bit          m_hist[$];
   logic [31:0] m_last = '0;
   bit          m_primed = 0;
   logic [31:0] m_q[$];
   bit          m_ovf = 0;

   always #5 clk_cog = ~clk_cog;

   cog_ctr_capture #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk_cog  (clk_cog),
      .res      (res),
      .ena      (ena),
      .cfg_set  (cfg_set),
      .cfg_data (cfg_data),
      .phs      (phs),
      .pin_in   (pin_in),
      .rd       (rd),
      .dout     (dout),
      .valid    (valid),
      .count    (count),
      .ovf      (ovf)
   );

   function automatic logic [31:0] mk(input int pin, input int mode, input bit delta);
      logic [31:0] v;
      v = '0;
      v[4:0] = pin[4:0];
      v[6:5] = mode[1:0];
      v[7]   = delta;
      return v;
   endfunction

   // Advance the model from the current inputs, then clock the DUT and settle.
   task automatic step();
      bit          ev;
      bit          prv;
      bit          cur;
      logic [31:0] d;
      if (res || !ena) begin
         m_pin = 0; m_mode = 0; m_delta = 0; m_hist.delete();
         m_last = '0; m_primed = 0; m_q.delete(); m_ovf = 0;
      end else if (cfg_set) begin
         m_pin = int'(cfg_data[4:0]); m_mode = int'(cfg_data[6:5]); m_delta = cfg_data[7];
         m_hist.delete(); m_primed = 0; m_q.delete(); m_ovf = 0;
      end else begin
         ev = 0;
         if (m_hist.size() >= 2) begin
            prv = m_hist[0];
            cur = m_hist[1];
            ev = (m_mode == 1 && !prv && cur) || (m_mode == 2 && prv && !cur) ||
                 (m_mode == 3 && prv != cur);
         end
         if (rd && m_q.size() > 0) void'(m_q.pop_front());
         if (ev) begin
            if (!m_delta || m_primed) begin
               d = m_delta ? phs[31:0] - m_last : phs[31:0];
               if (m_q.size() < DEPTH) m_q.push_back(d);
               else m_ovf = 1;
            end
            m_last = phs[31:0];
            m_primed = 1;
         end
         if (m_mode != 0) begin
            m_hist.push_back(pin_in[m_pin]);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
         end
      end
      @(posedge clk_cog);
      #1;
   endtask

   task automatic do_cfg(input logic [31:0] d);
      cfg_data = d;
      cfg_set  = 1'b1;
      step();
      cfg_set  = 1'b0;
   endtask

   task automatic test_reset();
      res = 1'b1;
      step();
      step();
      n_cmp++; if (dout !== 32'd0) begin n_bad++; $display("FAIL reset_dout got %h want 0", dout); end
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
      res = 1'b0;
   endtask

   // pin_in lags the physical pin by one register: a rise at phs=110 shows on pin_in with phs=111.
   task automatic test_raw_rise();
      do_cfg(mk(3, 1, 0));
      pin_in = '0;
      for (int c = 100; c <= 113; c++) begin
         phs = 33'(c);
         pin_in[3] = (c >= 111);
         step();
         if (c == 111) begin
            n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL raw_early_valid got %b want 0", valid); end
         end
         if (c == 112) begin
            n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL raw_valid got %b want 1", valid); end
            n_cmp++; if (dout !== 32'd112) begin n_bad++; $display("FAIL raw_dout got %0d want 112", dout); end
            n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL raw_count got %0d want 1", count); end
         end
      end
      rd = 1'b1; step(); rd = 1'b0;
   endtask

   task automatic test_delta_period();
      logic [31:0] base;
      logic [31:0] v;
      do_cfg(mk(0, 1, 1));
      pin_in = '0;
      base = $urandom;
      for (int c = 0; c < 210; c++) begin
         v = base + 32'(c);
         phs = {1'b1, v};
         pin_in[0] = ((c % 50) >= 10) && ((c % 50) < 35);
         step();
         if (c == 60) begin
            n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL period_prime_valid got %b want 0", valid); end
         end
      end
      n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL period_count got %0d want 3", count); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (dout !== 32'd50) begin n_bad++; $display("FAIL period_entry%0d got %0d want 50", k, dout); end
         rd = 1'b1; step(); rd = 1'b0;
      end
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL period_drained got %b want 0", valid); end
   endtask

   task automatic test_delta_wrap();
      do_cfg(mk(1, 1, 1));
      pin_in = '0; phs = '0;
      repeat (3) step();
      pin_in[1] = 1'b1; step();
      phs = 33'h0_FFFF_FFF0; step();
      pin_in[1] = 1'b0; phs = '0;
      repeat (3) step();
      pin_in[1] = 1'b1; step();
      phs = 33'h0_0000_0010; step();
      n_cmp++; if (dout !== 32'h20) begin n_bad++; $display("FAIL wrap_dout got %h want 00000020", dout); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf got %b want 0", ovf); end
      n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL wrap_count got %0d want 1", count); end
      rd = 1'b1; step(); rd = 1'b0;
   endtask

   task automatic test_overflow();
      logic [31:0] exp_v[7];
      int idx;
      do_cfg(mk(5, 3, 0));
      pin_in = '0;
      repeat (3) step();
      for (int e = 0; e < 6; e++) begin
         pin_in[5] = ~pin_in[5]; phs = {1'b0, $urandom}; step();
         exp_v[e] = $urandom; phs = {1'b0, exp_v[e]}; step();
         phs = {1'b0, $urandom}; step();
      end
      n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", count); end
      n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", ovf); end
      n_cmp++; if (dout !== exp_v[0]) begin n_bad++; $display("FAIL ovf_head got %h want %h", dout, exp_v[0]); end
      pin_in[5] = ~pin_in[5]; step();
      exp_v[6] = $urandom; phs = {1'b0, exp_v[6]}; rd = 1'b1; step(); rd = 1'b0;
      n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ovf_rdwr_count got %0d want 4", count); end
      for (int k = 0; k < 4; k++) begin
         idx = (k < 3) ? k + 1 : 6;
         n_cmp++; if (dout !== exp_v[idx]) begin n_bad++; $display("FAIL ovf_entry%0d got %h want %h", k, dout, exp_v[idx]); end
         rd = 1'b1; step(); rd = 1'b0;
      end
      n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", ovf); end
   endtask

   task automatic test_flush();
      for (int e = 0; e < 3; e++) begin
         pin_in[5] = ~pin_in[5]; step();
         phs = {1'b0, $urandom}; step();
         step();
      end
      n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL flush_pre_count got %0d want 3", count); end
      do_cfg(mk(5, 3, 0));
      rd = 1'b1; step(); rd = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count); end
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", valid); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL flush_ovf got %b want 0", ovf); end
      n_cmp++; if (dout !== 32'd0) begin n_bad++; $display("FAIL flush_dout got %h want 0", dout); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] p;
      do_cfg(mk(2, 1, 1));
      pin_in = '0;
      repeat (3) step();
      for (int e = 0; e < 3; e++) begin
         pin_in[2] = 1'b1; step();
         phs = {1'b0, $urandom}; step();
         pin_in[2] = 1'b0; step(); step();
      end
      n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL rstmid_pre_count got %0d want 2", count); end
      pin_in[2] = 1'b1; step();
      res = 1'b1; step(); res = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count got %0d want 0", count); end
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", valid); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovf got %b want 0", ovf); end
      step(); step();
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rstmid_lost_count got %0d want 0", count); end
      do_cfg(mk(2, 1, 1));
      step(); step();
      pin_in[2] = 1'b0; step(); step();
      pin_in[2] = 1'b1; step();
      p = $urandom; phs = {1'b0, p}; step();
      pin_in[2] = 1'b0; step(); step();
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rstmid_prime_count got %0d want 0", count); end
      pin_in[2] = 1'b1; step();
      phs = {1'b0, p + 32'd77}; step();
      n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL rstmid_delta_count got %0d want 1", count); end
      n_cmp++; if (dout !== 32'd77) begin n_bad++; $display("FAIL rstmid_delta_dout got %0d want 77", dout); end
   endtask

   task automatic test_random();
      logic [31:0] m_dout;
      do_cfg(mk(int'($urandom_range(0, 31)), 3, 0));
      for (int c = 0; c < 3000; c++) begin
         res      = ($urandom_range(0, 199) == 0);
         ena      = ($urandom_range(0, 199) != 0);
         cfg_set  = ($urandom_range(0, 79) == 0);
         cfg_data = $urandom;
         pin_in   = pin_in ^ ($urandom & $urandom);
         rd       = ($urandom_range(0, 3) == 0);
         phs      = {1'($urandom_range(0, 1)), $urandom};
         step();
         m_dout = (m_q.size() > 0) ? m_q[0] : '0;
         n_cmp++; if (dout !== m_dout) begin n_bad++; $display("FAIL rand_dout cyc %0d got %h want %h", c, dout, m_dout); end
         n_cmp++; if (valid !== (m_q.size() > 0)) begin n_bad++; $display("FAIL rand_valid cyc %0d got %b want %b", c, valid, m_q.size() > 0); end
         n_cmp++; if (count !== 3'(m_q.size())) begin n_bad++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count, m_q.size()); end
         n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL rand_ovf cyc %0d got %b want %b", c, ovf, m_ovf); end
      end
      res = 1'b0; ena = 1'b1; cfg_set = 1'b0; rd = 1'b0;
   endtask

   initial begin
      test_reset();
      test_raw_rise();
      test_delta_period();
      test_delta_wrap();
      test_overflow();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cog_ctr_capture.md
Name: cog_ctr_capture

Overview:
- Edge-timestamp capture stage directly downstream of the cog counter.
- Watches one selectable pin and, on a qualifying edge, snapshots the counter's phs[31:0], either raw or as a delta from the previous capture.
- Results are buffered in a small FIFO that the cog drains with a read strobe.
- Used for period, pulse-width and frequency measurement without software polling of PHS.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, log2(DEPTH).

Ports:
- clk_cog  input  1  cog clock; all state on rising edge
- res  input  1  synchronous reset, active-high
- ena  input  1  cog enable; low has the same effect as res, sampled synchronously
- cfg_set  input  1  load config from cfg_data
- cfg_data  input  32  [4:0] pin, [6:5] edge mode, [7] delta mode; other bits ignored
- phs  input  33  counter accumulator; only [31:0] used
- pin_in  input  32  pin inputs, already registered upstream
- rd  input  1  pop the head entry
- dout  output  32  head entry (first-word-fall-through)
- valid  output  1  FIFO non-empty
- count  output  AW+1  entries held, 0..DEPTH
- ovf  output  1  sticky overflow flag

Behaviour:
- Reset (res=1 or ena=0): clears cfg, the dly history, wr/rd pointers, last, primed and ovf.
  - Outputs after reset: dout=0, valid=0, count=0, ovf=0.
- cfg_set: registers the new cfg. In the same cycle it flushes the FIFO and clears ovf, primed and dly.
  - Any rd or capture pending in that cycle is discarded.
  - res has priority over cfg_set.
- Pin history:
  - Every cycle with mode!=00: dly <= {dly[0], pin_in[pin]}.
  - With mode==00, dly holds.
- Event (combinational from dly):
  - mode 01: dly==2'b01 (rise).
  - mode 10: dly==2'b10 (fall).
  - mode 11: dly[1]^dly[0] (both edges).
  - mode 00: never.
  - No event is allowed in the first cycle after cfg_set/reset (dly not yet valid for two samples).
- Capture timing:
  - A pin transition is sampled into dly[0] at edge k; the event is high during cycle k..k+1.
  - At edge k+1 the write occurs, using phs[31:0] as presented during that cycle.
  - valid rises after edge k+1.
  - Pin-to-valid latency is 2 clocks.
- Raw mode (delta=0): the entry is phs[31:0].
- Delta mode (delta=1): the entry is phs[31:0] - last, modulo 2^32 (wraps with no flag).
  - last <= phs[31:0] on every event.
  - The first event after reset/cfg_set only primes last (sets primed) and writes nothing.
- FIFO:
  - A write happens when the event occurs, data is produced (raw, or delta with primed), and the FIFO is not full.
  - Event with a full FIFO and no rd: entry dropped, ovf <= 1; ovf stays until res/ena low/cfg_set.
  - last still updates on a dropped delta event, so the next delta is relative to the dropped edge.
  - rd with valid=1 pops the head. rd with valid=0 is ignored: no pointer change, dout holds 0.
  - Simultaneous rd and write when full: both succeed, count unchanged, ovf not set.
  - Simultaneous rd and write when empty: the write lands; rd is ignored that cycle.
  - dout = mem[rd_ptr] when valid, else 0.
  - Pointers wrap modulo DEPTH; count is tracked explicitly (AW+1 bits) to distinguish full from empty.
- Edges closer than 1 clock apart cannot occur: pin_in is registered. Every qualifying dly pattern produces exactly one event.

Decomposition:
- Shared package cog_pkg holds:
  - cfg field positions (PIN_LSB=0, MODE_LSB=5, DELTA_BIT=7);
  - the mode encoding constants (MODE_OFF/RISE/FALL/BOTH).
- One sub-module: cog_fifo.
  - Parameterised DEPTH, synchronous-reset, FWFT.
  - Ports: wr, wdata, rd, rdata, valid, full, count, flush.
- Edge detect, delta arithmetic and ovf stay in cog_ctr_capture.

Test Plan:
- Raw rise capture:
  - Stimulus: pin 3, mode 01, delta 0; phs incrementing by 1 per clock from 100; pin 3 rises while phs=110 is presented.
  - Response: valid high 2 clocks after the pin change, dout=the phs value at the write edge (112 per the timing above), count=1.
- Delta period:
  - Stimulus: mode 01, delta 1, pin rises every 50 clocks, phs += 1 per clock.
  - Response: first rise writes nothing; then entries 50, 50, 50; valid only after the second rise.
- Delta wrap:
  - Stimulus: last=0xFFFF_FFF0; next capture at phs=0x0000_0010.
  - Response: dout=0x20, ovf=0.
- Overflow:
  - Stimulus: DEPTH=4, both-edge mode, 6 edges, no rd.
  - Response: count=4, ovf=1, entries are the first four; then rd in the same cycle as a 7th edge gives count=4 with the new entry at the tail.
- Flush and empty read:
  - Stimulus: 3 entries held, pulse cfg_set, then pulse rd.
  - Response: count=0, valid=0, ovf=0, dout=0, no underflow.
- Reset mid-operation:
  - Stimulus: assert res (or drop ena) with 2 entries held and an event pending.
  - Response: next cycle count=0, valid=0, ovf=0, the pending event is lost, and the first delta event after release only primes.
